// File: rtl/kick_pkg.sv
// Shared types and helpers for the kicker sequencer.
package kick_pkg;

    localparam int unsigned STRENGTH_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        READY,
        FIRE,
        COOLDOWN,
        FAULT
    } kick_state_t;

    // Limit a microsecond value to a ceiling.
    function automatic int unsigned clamp_us(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

    // Largest of three limits; sizes the shared microsecond counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/kick_sequencer_if.sv
// Command/power-stage signal bundle of the kicker sequencer.
interface kick_sequencer_if;
    import kick_pkg::*;

    logic                  arm;
    logic                  cap_full;
    logic                  kick_req;
    logic [STRENGTH_W-1:0] kick_strength;
    logic                  kick_ack;
    logic                  charge_en;
    logic                  fire;
    logic                  ready;
    logic                  fault;

    // Command side: drives arm/request, watches status.
    modport master (
        output arm, cap_full, kick_req, kick_strength,
        input  kick_ack, charge_en, fire, ready, fault
    );

    // Sequencer side.
    modport slave (
        input  arm, cap_full, kick_req, kick_strength,
        output kick_ack, charge_en, fire, ready, fault
    );

endinterface

// File: rtl/kick_tick_gen.sv
// Microsecond timebase: one-cycle tick every TICK_DIV clocks, restartable
// so that every state's duration starts on a fresh tick period.
module kick_tick_gen #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == LAST);

    // Prescaler count; restart forces the next cycle to be period cycle 0.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + ONE;
        end
    end

endmodule

// File: rtl/kick_sequencer.sv
// Kicker sequencer: charge, accept a strength-coded kick, fire a timed
// solenoid pulse, cool down, recharge. All outputs are registered from the
// next state so fire and charge_en can never overlap.
module kick_sequencer
    import kick_pkg::*;
#(
    parameter int unsigned TICK_DIV          = 50,
    parameter int unsigned US_PER_LSB        = 50,
    parameter int unsigned MAX_PULSE_US      = 5000,
    parameter int unsigned COOLDOWN_US       = 200000,
    parameter int unsigned CHARGE_TIMEOUT_US = 8000000
) (
    input  logic             clk,
    input  logic             rst_n,
    kick_sequencer_if.slave  bus
);

    localparam int unsigned MAX_US = max3(MAX_PULSE_US, COOLDOWN_US, CHARGE_TIMEOUT_US);
    localparam int unsigned US_W   = $clog2(MAX_US + 1);
    localparam int unsigned PROD_W = STRENGTH_W + $clog2(US_PER_LSB + 1);

    localparam logic [US_W-1:0] US_ONE     = US_W'(1);
    localparam logic [US_W-1:0] US_SAT     = '1;
    localparam logic [US_W:0]   US_ONE_EXT = (US_W+1)'(1);

    // Synchronizer and FSM state
    logic                  cap_meta_reg;
    logic                  cap_full_s_reg;
    kick_state_t           state_reg;
    kick_state_t           state_next;
    logic [US_W-1:0]       us_cnt_reg;
    logic [STRENGTH_W-1:0] strength_reg;

    // Registered outputs
    logic kick_ack_reg;
    logic charge_en_reg;
    logic fire_reg;
    logic ready_reg;
    logic fault_reg;

    // Timing helpers
    logic              tick;
    logic              restart;
    logic              accept;
    logic              us_done;
    logic [US_W-1:0]   us_limit;
    logic [PROD_W-1:0] pulse_prod;
    logic [US_W-1:0]   pulse_us;

    kick_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Product is wide enough for 127*US_PER_LSB, then clamped to the pulse ceiling.
    assign pulse_prod = PROD_W'(strength_reg) * PROD_W'(US_PER_LSB);
    assign pulse_us   = US_W'(clamp_us(32'(pulse_prod), MAX_PULSE_US));

    // A request is taken once per READY visit; the ack register blocks a
    // second acceptance while the requester is still seeing the ack.
    assign accept = (state_reg == READY) && bus.arm && bus.kick_req && !kick_ack_reg;

    // Duration limit of the current state, in microseconds.
    always_comb begin
        us_limit = US_W'(CHARGE_TIMEOUT_US);
        case (state_reg)
            FIRE:     us_limit = pulse_us;
            COOLDOWN: us_limit = US_W'(COOLDOWN_US);
            default:  us_limit = US_W'(CHARGE_TIMEOUT_US);
        endcase
    end

    // The tick that completes the last microsecond of the current state.
    assign us_done = tick && (({1'b0, us_cnt_reg} + US_ONE_EXT) >= {1'b0, us_limit});

    // Next-state selection; dropping arm overrides everything.
    always_comb begin
        state_next = state_reg;
        if (!bus.arm) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:     state_next = CHARGE;
                CHARGE: begin
                    if (cap_full_s_reg)  state_next = READY;
                    else if (us_done)    state_next = FAULT;
                end
                READY: begin
                    if (kick_ack_reg && (strength_reg != '0)) state_next = FIRE;
                end
                FIRE:     if (us_done) state_next = COOLDOWN;
                COOLDOWN: if (us_done) state_next = CHARGE;
                FAULT:    state_next = FAULT;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Every state entry restarts both the prescaler and the microsecond counter.
    assign restart = (state_next != state_reg);

    // Two-flop synchronizer for the asynchronous comparator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_meta_reg   <= 1'b0;
            cap_full_s_reg <= 1'b0;
        end else begin
            cap_meta_reg   <= bus.cap_full;
            cap_full_s_reg <= cap_meta_reg;
        end
    end

    // FSM state, saturating us counter, strength latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            us_cnt_reg    <= '0;
            strength_reg  <= '0;
            kick_ack_reg  <= 1'b0;
            charge_en_reg <= 1'b0;
            fire_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (restart) begin
                us_cnt_reg <= '0;
            end else if (tick && (us_cnt_reg != US_SAT)) begin
                us_cnt_reg <= us_cnt_reg + US_ONE;
            end
            if (accept) begin
                strength_reg <= bus.kick_strength;
            end
            kick_ack_reg  <= accept;
            charge_en_reg <= (state_next == CHARGE) || (state_next == READY);
            fire_reg      <= (state_next == FIRE);
            ready_reg     <= (state_next == READY);
            fault_reg     <= (state_next == FAULT);
        end
    end

    assign bus.kick_ack  = kick_ack_reg;
    assign bus.charge_en = charge_en_reg;
    assign bus.fire      = fire_reg;
    assign bus.ready     = ready_reg;
    assign bus.fault     = fault_reg;

endmodule

// File: tb/tb_kick_sequencer.sv
// Directed/randomized bench for kick_sequencer with small timing parameters.
module tb_kick_sequencer;

    localparam int unsigned TICK_DIV          = 4;
    localparam int unsigned US_PER_LSB        = 2;
    localparam int unsigned MAX_PULSE_US      = 100;
    localparam int unsigned COOLDOWN_US       = 10;
    localparam int unsigned CHARGE_TIMEOUT_US = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    kick_sequencer_if kif ();

    kick_sequencer #(
        .TICK_DIV          (TICK_DIV),
        .US_PER_LSB        (US_PER_LSB),
        .MAX_PULSE_US      (MAX_PULSE_US),
        .COOLDOWN_US       (COOLDOWN_US),
        .CHARGE_TIMEOUT_US (CHARGE_TIMEOUT_US)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    always #5 clk = ~clk;

    // Reference: pulse length in clock cycles straight from the strength rule.
    function automatic int exp_pulse_cycles(input int s);
        int us;
        us = s * int'(US_PER_LSB);
        if (us > int'(MAX_PULSE_US)) us = int'(MAX_PULSE_US);
        return us * int'(TICK_DIV);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // fire and charge_en must never be high together.
    always @(negedge clk) begin
        n_checks++;
        assert (!(kif.fire && kif.charge_en)) else begin
            n_fail++;
            $error("FAIL excl: fire=%0b charge_en=%0b expected not both 1", kif.fire, kif.charge_en);
        end
    end

    // Request already driven while READY: ack the next cycle, then drop it.
    task automatic accept_req();
        step();
        chk("ack_rise", kif.kick_ack, 1);
        kif.kick_req = 1'b0;
        step();
        chk("ack_fall", kif.kick_ack, 0);
    endtask

    // Measure pulse and cooldown after an accepted request; optionally
    // raise a new request during cooldown and confirm it waits for READY.
    task automatic fire_phase(input int s, input bit pend, input int s2);
        int cnt;
        bit saw_ack;
        if (s == 0) begin
            chk("noop_fire", kif.fire, 0);
            chk("noop_ready", kif.ready, 1);
            step();
            chk("noop_fire2", kif.fire, 0);
            chk("noop_ack2", kif.kick_ack, 0);
            chk("noop_ready2", kif.ready, 1);
            return;
        end
        chk("fire_rise", kif.fire, 1);
        cnt = 0;
        while (kif.fire === 1'b1 && cnt < 2000) begin
            cnt++;
            step();
        end
        chk("fire_len", cnt, exp_pulse_cycles(s));
        if (pend) begin
            kif.kick_strength = 7'(s2);
            kif.kick_req = 1'b1;
        end
        cnt = 0;
        saw_ack = 1'b0;
        while (kif.charge_en !== 1'b1 && cnt < 2000) begin
            if (kif.kick_ack === 1'b1) saw_ack = 1'b1;
            cnt++;
            step();
        end
        chk("cooldown_len", cnt, COOLDOWN_US * TICK_DIV);
        if (pend) chk("no_early_ack", 32'(saw_ack), 0);
        chk("recharge_not_ready", kif.ready, 0);
        step();
        chk("ready_back", kif.ready, 1);
        chk("ack_not_yet", kif.kick_ack, 0);
    endtask

    task automatic do_kick(input int s);
        $display("kick strength=%0d expected pulse=%0d cycles", s, exp_pulse_cycles(s));
        kif.kick_strength = 7'(s);
        kif.kick_req = 1'b1;
        accept_req();
        fire_phase(s, 1'b0, 0);
    endtask

    initial begin
        int cnt;
        int s;
        int s2;
        bit saw_ack;
        bit fault_held;

        kif.arm           = 1'b0;
        kif.cap_full      = 1'b0;
        kif.kick_req      = 1'b0;
        kif.kick_strength = '0;

        // Reset state
        repeat (3) step();
        chk("rst_ack", kif.kick_ack, 0);
        chk("rst_charge", kif.charge_en, 0);
        chk("rst_fire", kif.fire, 0);
        chk("rst_ready", kif.ready, 0);
        chk("rst_fault", kif.fault, 0);
        rst_n = 1'b1;
        step();
        chk("idle_charge", kif.charge_en, 0);

        // Arm, charge, capacitor full after 20 cycles, 2-flop sync latency
        kif.arm = 1'b1;
        step();
        chk("charge_on", kif.charge_en, 1);
        chk("charge_not_ready", kif.ready, 0);
        repeat (19) step();
        kif.cap_full = 1'b1;
        step();
        step();
        chk("sync_lat2", kif.ready, 0);
        step();
        chk("sync_lat3", kif.ready, 1);
        chk("ready_charge", kif.charge_en, 1);
        $display("armed and ready");

        // Directed kicks: nominal, clamp, no-op
        do_kick(5);
        do_kick(127);
        do_kick(0);

        // Randomized strengths
        for (int k = 0; k < 4; k++) begin
            do_kick(int'($urandom_range(1, 127)));
        end

        // Request held through cooldown: no ack until READY
        s  = int'($urandom_range(1, 60));
        s2 = int'($urandom_range(1, 60));
        $display("kick strength=%0d with pending strength=%0d", s, s2);
        kif.kick_strength = 7'(s);
        kif.kick_req = 1'b1;
        accept_req();
        fire_phase(s, 1'b1, s2);
        accept_req();
        fire_phase(s2, 1'b0, 0);

        // arm drop at fire cycle 10 truncates the pulse
        $display("kick strength=127 truncated by arm=0");
        kif.kick_strength = 7'h7F;
        kif.kick_req = 1'b1;
        accept_req();
        chk("trunc_fire_rise", kif.fire, 1);
        repeat (9) step();
        chk("trunc_fire10", kif.fire, 1);
        kif.arm = 1'b0;
        step();
        chk("trunc_fire_off", kif.fire, 0);
        chk("trunc_charge_off", kif.charge_en, 0);
        chk("trunc_ready_off", kif.ready, 0);
        step();
        chk("idle_hold_charge", kif.charge_en, 0);
        kif.arm = 1'b1;
        step();
        chk("rearm_charge", kif.charge_en, 1);
        step();
        chk("rearm_ready", kif.ready, 1);

        // Reset mid-fire
        $display("kick strength=127 interrupted by reset");
        kif.kick_strength = 7'h7F;
        kif.kick_req = 1'b1;
        accept_req();
        repeat (10) step();
        chk("rstfire_on", kif.fire, 1);
        rst_n = 1'b0;
        step();
        chk("rstfire_off", kif.fire, 0);
        chk("rstfire_charge", kif.charge_en, 0);
        chk("rstfire_ready", kif.ready, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_charge", kif.charge_en, 1);
        cnt = 0;
        while (kif.ready !== 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        chk("post_rst_ready", kif.ready, 1);

        // Charge timeout -> FAULT, cleared by arm=0
        $display("charge timeout with cap_full held low");
        kif.cap_full = 1'b0;
        kif.arm = 1'b0;
        repeat (3) step();
        chk("to_idle_charge", kif.charge_en, 0);
        kif.arm = 1'b1;
        step();
        chk("to_charge_on", kif.charge_en, 1);
        cnt = 0;
        while (kif.charge_en === 1'b1 && cnt < 1000) begin
            cnt++;
            step();
        end
        chk("timeout_len", cnt, CHARGE_TIMEOUT_US * TICK_DIV);
        chk("fault_set", kif.fault, 1);
        chk("fault_charge", kif.charge_en, 0);
        chk("fault_ready", kif.ready, 0);
        kif.kick_strength = 7'd3;
        kif.kick_req = 1'b1;
        saw_ack = 1'b0;
        fault_held = 1'b1;
        repeat (6) begin
            step();
            if (kif.kick_ack === 1'b1) saw_ack = 1'b1;
            if (kif.fault !== 1'b1) fault_held = 1'b0;
        end
        chk("fault_no_ack", 32'(saw_ack), 0);
        chk("fault_held", 32'(fault_held), 1);
        kif.arm = 1'b0;
        kif.kick_req = 1'b0;
        step();
        chk("fault_clear", kif.fault, 0);
        chk("fault_clear_charge", kif.charge_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
